// File: rtl/core_fetch_pc_pkg.sv
// Shared constants and types for the instruction-fetch stage.
//   REG_DATA_WIDTH   - default PC / instruction width
//   FETCH_BOOT_ADDR  - default fetch PC after reset
//   FETCH_FIFO_DEPTH - default instruction buffer depth
//   FETCH_PC_INCR    - sequential PC step in bytes
//   fetch_state_e    - fetch FSM state encoding
package core_fetch_pc_pkg;

  localparam int unsigned REG_DATA_WIDTH   = 32;
  localparam logic [31:0] FETCH_BOOT_ADDR  = 32'h0000_0000;
  localparam int unsigned FETCH_FIFO_DEPTH = 2;
  localparam int unsigned FETCH_PC_INCR    = 4;

  typedef enum logic [1:0] {
    FetchIdle = 2'd0,
    FetchReq  = 2'd1,
    FetchWait = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/core_fetch_fifo.sv
// Synchronous FIFO with a registered head entry.
//   clk, rst_n - clock, asynchronous active-low reset
//   flush      - empty the FIFO (wins over push and pop)
//   push/wdata - write an entry
//   ready      - consumer pops the head when valid & ready
//   valid      - head entry valid
//   rdata      - head entry; holds its last value while valid is low
//   count      - number of stored entries
module core_fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         ready,
  output logic                         valid,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             valid_q, pop;
  logic [WIDTH-1:0] head_q, head_d;

  always_comb begin
    pop      = valid_q & ready;
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(push) - CntW'(pop);
    // The entry becoming head may be the one written this very cycle.
    head_d   = (push && (wr_ptr_q == rd_ptr_d)) ? wdata : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      if (count_d != '0) begin
        head_q <= head_d;
      end
    end
  end

  assign valid = valid_q;
  assign rdata = head_q;
  assign count = count_q;

endmodule

// File: rtl/core_fetch_pc.sv
// Instruction-fetch stage: fetch PC, single-outstanding req/gnt/rvalid memory
// requests and an instruction buffer feeding decode/execute.
//   clk_i, rstn_i      - clock, asynchronous active-low reset
//   redirect_i/_pc_i   - one-cycle redirect pulse and new target PC (flushes)
//   instr_req_o/addr_o - memory request and word-aligned address
//   instr_gnt_i        - request accepted this cycle
//   instr_rvalid_i/rdata_i - response valid and instruction word
//   instr_valid_o/instr_o/instr_pc_o - buffer head and its PC
//   instr_ready_i      - consumer pops the head when valid & ready
module core_fetch_pc
  import core_fetch_pc_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = REG_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] BOOT_ADDR  = DATA_WIDTH'(FETCH_BOOT_ADDR),
  parameter int unsigned           FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  instr_req_o,
  output logic [DATA_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o,
  input  logic                  instr_ready_i
);

  localparam int unsigned     CntW     = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  fetch_state_e          state_q;
  logic [DATA_WIDTH-1:0] fetch_pc_q, pend_pc_q, redirect_pc_aligned, pc_incr;
  logic                  drop_q, issue, push, pop;
  logic [CntW-1:0]       fifo_count, count_after;
  logic [2*DATA_WIDTH-1:0] fifo_head;

  assign redirect_pc_aligned = redirect_pc_i & ~DATA_WIDTH'(3);
  assign pc_incr             = DATA_WIDTH'(FETCH_PC_INCR);

  // A discarded response frees the only outstanding slot, so the next request
  // goes out in that same cycle instead of waiting for a state change.
  assign issue = (state_q == FetchReq) ||
                 ((state_q == FetchWait) && drop_q && instr_rvalid_i);

  assign push        = (state_q == FetchWait) && instr_rvalid_i && !drop_q && !redirect_i;
  assign pop         = instr_valid_o && instr_ready_i;
  assign count_after = fifo_count + CntW'(1) - CntW'(pop);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= FetchIdle;
      fetch_pc_q <= BOOT_ADDR;
      pend_pc_q  <= '0;
      drop_q     <= 1'b0;
    end else if (issue) begin
      if (instr_gnt_i) begin
        pend_pc_q  <= fetch_pc_q;
        state_q    <= FetchWait;
        drop_q     <= redirect_i;
        fetch_pc_q <= redirect_i ? redirect_pc_aligned : fetch_pc_q + pc_incr;
      end else begin
        // Ungranted request is withdrawn on redirect and reissued at the target.
        state_q <= FetchReq;
        drop_q  <= 1'b0;
        if (redirect_i) begin
          fetch_pc_q <= redirect_pc_aligned;
        end
      end
    end else begin
      unique case (state_q)
        FetchIdle: begin
          if (redirect_i) begin
            fetch_pc_q <= redirect_pc_aligned;
            state_q    <= FetchReq;
          end else if (fifo_count < DepthCnt) begin
            state_q <= FetchReq;
          end
        end
        FetchWait: begin
          if (redirect_i) begin
            fetch_pc_q <= redirect_pc_aligned;
            if (instr_rvalid_i) begin
              state_q <= FetchReq;
            end else begin
              drop_q <= 1'b1;
            end
          end else if (instr_rvalid_i) begin
            state_q <= (count_after < DepthCnt) ? FetchReq : FetchIdle;
          end
        end
        default: ;
      endcase
    end
  end

  assign instr_req_o  = issue;
  assign instr_addr_o = fetch_pc_q;

  core_fetch_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rstn_i),
    .flush (redirect_i),
    .push  (push),
    .wdata ({instr_rdata_i, pend_pc_q}),
    .ready (instr_ready_i),
    .valid (instr_valid_o),
    .rdata (fifo_head),
    .count (fifo_count)
  );

  assign instr_o    = fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign instr_pc_o = fifo_head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_core_fetch_pc.sv
// Directed bench for core_fetch_pc. A small memory responder returns
// ~address as the instruction word, a programmable number of cycles after gnt.
module tb_core_fetch_pc;

  logic        clk = 1'b0, rstn = 1'b0, redirect = 1'b0, ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_req, instr_valid;
  logic [31:0] instr_addr, instr, instr_pc;
  logic        instr_gnt = 1'b0, instr_rvalid = 1'b0;
  logic [31:0] instr_rdata = '0;

  // Memory responder knobs and state.
  bit          gnt_en = 1'b1;
  int          lat = 1;
  int          stale_req = 0, stale_done = 0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] gnt_log [256];
  int          gnt_total = 0;

  int tests = 0, fails = 0;

  core_fetch_pc dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .redirect_i     (redirect),
    .redirect_pc_i  (redirect_pc),
    .instr_req_o    (instr_req),
    .instr_addr_o   (instr_addr),
    .instr_gnt_i    (instr_gnt),
    .instr_rvalid_i (instr_rvalid),
    .instr_rdata_i  (instr_rdata),
    .instr_valid_o  (instr_valid),
    .instr_o        (instr),
    .instr_pc_o     (instr_pc),
    .instr_ready_i  (ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    instr_rvalid = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        instr_rvalid = 1'b1;
        instr_rdata  = ~pend_addr;
        pend         = 1'b0;
      end
    end else if (stale_req != stale_done) begin
      instr_rvalid = 1'b1;
      instr_rdata  = 32'hDEAD_BEEF;
      stale_done++;
    end
    #1;
    instr_gnt = gnt_en && instr_req;
    if (instr_gnt) begin
      pend      = 1'b1;
      pend_cnt  = lat;
      pend_addr = instr_addr;
      gnt_log[gnt_total] = instr_addr;
      gnt_total++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rstn = 1'b0;
    redirect = 1'b0;
    repeat (4) tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    gnt_en = 1'b1; lat = 1; ready = 1'b1;
    rstn = 1'b0;
    repeat (4) tick();
    tests++; if (instr_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", instr_req); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    tests++; if (instr !== 32'h0) begin fails++; $display("FAIL rst_instr: got %h want 0", instr); end
    tests++; if (instr_pc !== 32'h0) begin fails++; $display("FAIL rst_pc: got %h want 0", instr_pc); end
    rstn = 1'b1;
    tick();
    tests++; if (instr_req !== 1'b1) begin fails++; $display("FAIL first_req: got %b want 1", instr_req); end
    tests++; if (instr_addr !== 32'h0) begin fails++; $display("FAIL first_addr: got %h want 0", instr_addr); end
    tick();
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL early_valid: got %b want 0", instr_valid); end
    tick();
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL valid_at_3: got %b want 1", instr_valid); end
    tests++; if (instr_pc !== 32'h0) begin fails++; $display("FAIL pc_at_3: got %h want 0", instr_pc); end
    tests++; if (instr !== 32'hFFFF_FFFF) begin fails++; $display("FAIL instr_at_3: got %h want ffffffff", instr); end
  endtask

  task automatic test_stream;
    logic [31:0] pcs [8];
    logic [31:0] words [8];
    int nv, base;
    gnt_en = 1'b1; lat = 1; ready = 1'b1;
    apply_reset();
    base = gnt_total;
    nv = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (instr_valid && nv < 8) begin pcs[nv] = instr_pc; words[nv] = instr; nv++; end
    end
    tests++; if (nv != 6) begin fails++; $display("FAIL stream_rate: got %0d valid cycles want 6", nv); end
    tests++; if (pcs[0] !== 32'h0) begin fails++; $display("FAIL stream_pc0: got %h want 0", pcs[0]); end
    tests++; if (pcs[1] !== 32'h4) begin fails++; $display("FAIL stream_pc1: got %h want 4", pcs[1]); end
    tests++; if (pcs[2] !== 32'h8) begin fails++; $display("FAIL stream_pc2: got %h want 8", pcs[2]); end
    tests++; if (words[2] !== 32'hFFFF_FFF7) begin fails++; $display("FAIL stream_w2: got %h want fffffff7", words[2]); end
    tests++; if (gnt_log[base+2] !== 32'h8) begin fails++; $display("FAIL stream_addr2: got %h want 8", gnt_log[base+2]); end
  endtask

  task automatic test_gnt_stall;
    int base;
    gnt_en = 1'b0; lat = 1; ready = 1'b1;
    apply_reset();
    base = gnt_total;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (instr_req !== 1'b1 || instr_addr !== 32'h0) begin fails++; $display("FAIL stall_hold%0d: got req=%b addr=%h want req=1 addr=0", i, instr_req, instr_addr); end
    end
    tests++; if (gnt_total != base) begin fails++; $display("FAIL stall_nogrant: got %0d grants want 0", gnt_total - base); end
    gnt_en = 1'b1;
    tick();
    tests++; if (instr_addr !== 32'h4) begin fails++; $display("FAIL stall_advance: got %h want 4", instr_addr); end
    tick();
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin fails++; $display("FAIL stall_word: got valid=%b pc=%h want 1/0", instr_valid, instr_pc); end
  endtask

  task automatic test_ready_stall;
    logic [31:0] pcs [3];
    int nv, base;
    gnt_en = 1'b1; lat = 1; ready = 1'b0;
    apply_reset();
    base = gnt_total;
    repeat (10) tick();
    tests++; if (instr_req !== 1'b0) begin fails++; $display("FAIL full_req: got %b want 0", instr_req); end
    tests++; if (gnt_total - base != 2) begin fails++; $display("FAIL full_grants: got %0d want 2", gnt_total - base); end
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin fails++; $display("FAIL full_head: got valid=%b pc=%h want 1/0", instr_valid, instr_pc); end
    ready = 1'b1;
    nv = 0;
    for (int i = 0; i < 20 && nv < 3; i++) begin
      if (instr_valid) begin pcs[nv] = instr_pc; nv++; end
      tick();
    end
    tests++; if (nv != 3) begin fails++; $display("FAIL drain_count: got %0d want 3", nv); end
    else begin
      tests++; if (pcs[0] !== 32'h0 || pcs[1] !== 32'h4 || pcs[2] !== 32'h8) begin fails++; $display("FAIL drain_order: got %h %h %h want 0 4 8", pcs[0], pcs[1], pcs[2]); end
    end
    tests++; if (gnt_log[base+2] !== 32'h8) begin fails++; $display("FAIL resume_addr: got %h want 8", gnt_log[base+2]); end
  endtask

  task automatic test_redirect_wait;
    int base, n;
    gnt_en = 1'b1; lat = 3; ready = 1'b1;
    apply_reset();
    base = gnt_total;
    n = 0;
    while (gnt_total - base < 3 && n < 60) begin tick(); n++; end
    tests++; if (gnt_total - base != 3 || gnt_log[base+2] !== 32'h8) begin fails++; $display("FAIL rw_setup: got %0d grants want 3 ending at 8", gnt_total - base); end
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rw_flush: got valid=%b want 0", instr_valid); end
    tests++; if (instr_req !== 1'b0) begin fails++; $display("FAIL rw_noreq: got req=%b want 0", instr_req); end
    n = 0;
    while (!instr_valid && n < 40) begin tick(); n++; end
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL rw_timeout: got valid=%b want 1", instr_valid); end
    tests++; if (instr_pc !== 32'h100) begin fails++; $display("FAIL rw_pc: got %h want 100", instr_pc); end
    tests++; if (instr !== 32'hFFFF_FEFF) begin fails++; $display("FAIL rw_instr: got %h want fffffeff", instr); end
    tests++; if (gnt_log[base+3] !== 32'h100) begin fails++; $display("FAIL rw_addr: got %h want 100", gnt_log[base+3]); end
  endtask

  task automatic test_redirect_req;
    int base, n;
    gnt_en = 1'b1; lat = 1; ready = 1'b0;
    apply_reset();
    base = gnt_total;
    repeat (3) tick();
    gnt_en = 1'b0;
    tick();
    tests++; if (instr_req !== 1'b1 || instr_addr !== 32'h4 || instr_valid !== 1'b1) begin fails++; $display("FAIL rr_setup: got req=%b addr=%h valid=%b want 1/4/1", instr_req, instr_addr, instr_valid); end
    redirect = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect = 1'b0;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rr_flush: got valid=%b want 0", instr_valid); end
    tests++; if (instr_req !== 1'b1 || instr_addr !== 32'h200) begin fails++; $display("FAIL rr_addr: got req=%b addr=%h want 1/200", instr_req, instr_addr); end
    gnt_en = 1'b1; ready = 1'b1;
    n = 0;
    while (!instr_valid && n < 40) begin tick(); n++; end
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin fails++; $display("FAIL rr_pc: got valid=%b pc=%h want 1/200", instr_valid, instr_pc); end
    tests++; if (instr !== 32'hFFFF_FDFF) begin fails++; $display("FAIL rr_instr: got %h want fffffdff", instr); end
    tests++; if (gnt_log[base+1] !== 32'h200) begin fails++; $display("FAIL rr_gnt: got %h want 200", gnt_log[base+1]); end
  endtask

  task automatic test_back_to_back;
    int base, n;
    gnt_en = 1'b1; lat = 3; ready = 1'b1;
    apply_reset();
    base = gnt_total;
    n = 0;
    while (gnt_total - base < 1 && n < 20) begin tick(); n++; end
    redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h400;
    tick();
    redirect = 1'b0;
    n = 0;
    while (!instr_valid && n < 40) begin tick(); n++; end
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h400) begin fails++; $display("FAIL b2b_pc: got valid=%b pc=%h want 1/400", instr_valid, instr_pc); end
  endtask

  task automatic test_reset_mid_wait;
    int base, n;
    gnt_en = 1'b1; lat = 3; ready = 1'b0;
    apply_reset();
    base = gnt_total;
    n = 0;
    while (gnt_total - base < 2 && n < 60) begin tick(); n++; end
    tests++; if (instr_valid !== 1'b1 || instr_req !== 1'b0) begin fails++; $display("FAIL rmw_setup: got valid=%b req=%b want 1/0", instr_valid, instr_req); end
    rstn = 1'b0;
    #1;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rmw_valid: got %b want 0", instr_valid); end
    tests++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin fails++; $display("FAIL rmw_head: got instr=%h pc=%h want 0/0", instr, instr_pc); end
    repeat (4) tick();
    rstn = 1'b1;
    base = gnt_total;
    tick();
    stale_req++;
    ready = 1'b1;
    n = 0;
    while (!instr_valid && n < 40) begin tick(); n++; end
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin fails++; $display("FAIL rmw_pc: got valid=%b pc=%h want 1/0", instr_valid, instr_pc); end
    tests++; if (instr !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rmw_stale: got %h want ffffffff", instr); end
    tests++; if (gnt_log[base] !== 32'h0) begin fails++; $display("FAIL rmw_boot: got %h want 0", gnt_log[base]); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gnt_stall();
    test_ready_stall();
    test_redirect_wait();
    test_redirect_req();
    test_back_to_back();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
